seq_detect_scheduler: RTL
=========================

// Module: seq_detect_scheduler
// PURPOSE
//  Time-shares one 1-bit seq_detector cell (2-bit state in/out) between NREQ byte streams.
//  Round-robin grants a requester's byte and feeds it through the cell MSB-first, one bit per clock.
//  Each requester has a saved 2-bit detector context, so a pattern can span that requester's bytes.
//  Returns an 8-bit match mask per byte. Sequential replacement for an 8-cell combinational chain.
// PARAMETERS
//  NREQ   4  number of requester streams (>=2)
//  DW     8  bits per request word; fixed at 8 for the mask layout
//  IDW    2  width of rsp_id, = clog2(NREQ)
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst        in   1         synchronous, active-high reset
//  req_valid  in   NREQ      requester i has a byte pending
//  req_data   in   NREQ*DW   byte of requester i at [i*8 +: 8], bit 7 processed first
//  req_ready  out  NREQ      one-hot grant; byte accepted when valid&ready
//  ctx_clear  in   NREQ      force context of requester i to 2'b00
//  rsp_valid  out  1         result available
//  rsp_ready  in   1         consumer accepts result
//  rsp_id     out  IDW       requester index of the result
//  rsp_mask   out  DW        cell out bits; mask[7] is for data bit 7, mask[0] for data bit 0
//  rsp_state  out  2         cell state after data bit 0 (new context)
//  busy       out  1         high in SHIFT or RESP
// BEHAVIOUR
//  Reset: FSM=IDLE, ctx[all]=2'b00, rr_ptr=0, rsp_valid=0, rsp_mask=0, rsp_id=0, rsp_state=0, busy=0.
//  req_ready is 0 while rst=1.
//  FSM states:
//   IDLE : req_ready = one-hot of first valid requester at or after rr_ptr (cyclic). No valid -> all 0.
//          Accept: load sh<=byte, cur<=ctx[win], id<=win, cnt<=7, go to SHIFT.
//   SHIFT: cell in=sh[7], state_in=cur. Registers: mask[cnt]<=out, cur<=state_out, sh<<=1, cnt--.
//          When cnt==0, write ctx[id]<=state_out and go to RESP. Exactly 8 SHIFT cycles.
//   RESP : rsp_valid=1; id, mask and state are held stable.
//          On rsp_ready: rr_ptr<=(id+1) mod NREQ, go to IDLE.
//  Latency: accept at edge t -> rsp_valid high from t+8 (9th cycle after the accept cycle).
//   Throughput is at most one byte per 10 cycles (1 IDLE + 8 SHIFT + 1 RESP min).
//  req_ready is 0 in SHIFT and RESP. Requesters hold data until granted; valid may drop unserved.
//  rsp_ready held low: stays in RESP indefinitely, no new grant.
//  ctx_clear[i], i != active id or FSM=IDLE: ctx[i]<=0 next edge.
//   Same cycle as accept of i: the grant uses the pre-clear ctx, and ctx is then cleared.
//  ctx_clear[id] while SHIFT for that id: a sticky flag is set.
//   The final writeback stores 2'b00 instead of state_out. rsp_state still reports the true state_out.
//   The flag clears on return to IDLE.
//  rst mid-operation: everything returns to reset values next edge. The partial byte is dropped with no response.
//  rr_ptr wraps NREQ-1 -> 0. A lone requester is granted back-to-back.
// STRUCTURE
//  Package seq_det_pkg holds:
//   - ST_W=2 and CTX_RESET=2'b00
//   - FSM enum: IDLE, SHIFT, RESP
//   - BIT_CNT_W=3
//  Sub-module rr_arbiter #(NREQ): inputs req and ptr, output one-hot gnt (combinational).
//  Instances: one rr_arbiter and one seq_detector cell. The context array is NREQ x 2 flops.
// TESTING (golden model = chain of seq_detector cells seeded with the stated context)
//  1. Reset, then req_valid=4'b0001 with data0=8'hA5.
//     -> req_ready=4'b0001 in the same cycle; rsp_valid 9 cycles later; rsp_id=0.
//     -> mask and state equal the 8-cell chain from 2'b00.
//  2. Req1 sends 8'h0F then 8'hF0 with no clear in between.
//     -> The second mask equals bits 7..0 of the 16-cell chain over 16'h0FF0.
//  3. req_valid=4'b1111 held, rsp_ready=1.
//     -> Grant order 0,1,2,3,0. Each requester is served once per 4 results.
//  4. rsp_ready=0 for 5 cycles in RESP.
//     -> rsp_valid, id, mask and state stay constant; req_ready=0; the next grant follows rsp_ready.
//  5. ctx_clear[2] pulsed in the 3rd SHIFT cycle of req2's byte.
//     -> ctx[2]=2'b00 afterwards; the next req2 byte matches the chain from 2'b00.
//  6. rst pulsed in the 4th SHIFT cycle.
//     -> Next cycle: IDLE, rsp_valid=0, all ctx=2'b00, rr_ptr=0; no response for the dropped byte.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the time-shared sequence detector.
package seq_det_pkg;

    // Width of a detector context (cell state).
    localparam int ST_W      = 2;
    // Context value after reset or a context clear.
    localparam logic [ST_W-1:0] CTX_RESET = 2'b00;
    // Width of the bit counter walking a byte MSB-first.
    localparam int BIT_CNT_W = 3;

    // Scheduler FSM: wait for a grant, shift 8 bits, present the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    logic found;
    int   idx;

    // Scan cyclically from ptr and grant the first active request.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detector.sv
// One bit-serial cell of an overlapping "101" Mealy detector.
// States: 00 nothing seen, 01 seen "1", 10 seen "10"; 11 is unused and behaves as 00.
module seq_detector
    import seq_det_pkg::*;
(
    input  logic            in_i,
    input  logic [ST_W-1:0] state_i,
    output logic            out_o,
    output logic [ST_W-1:0] state_o
);

    // Next state and match output for one input bit.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        out_o   = 1'b0;
        state_o = 2'b00;
        case (state_i)
            2'b01: state_o = in_i ? 2'b01 : 2'b10;
            2'b10: begin
                out_o   = in_i;
                state_o = in_i ? 2'b01 : 2'b00;
            end
            default: state_o = in_i ? 2'b01 : 2'b00;
        endcase
    end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Time-shares one seq_detector cell between NREQ byte streams, MSB-first,
// keeping a saved detector context per requester so patterns span bytes.
module seq_detect_scheduler
    import seq_det_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0]  req_ready_o,
    input  logic [NREQ-1:0]  ctx_clear_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [IDW-1:0]   rsp_id_o,
    output logic [DW-1:0]    rsp_mask_o,
    output logic [ST_W-1:0]  rsp_state_o,
    output logic             busy_o
);

    state_e               state_q, state_d;
    logic [ST_W-1:0]      ctx_q [NREQ];
    logic [ST_W-1:0]      ctx_d [NREQ];
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]        sh_q, sh_d;
    logic [ST_W-1:0]      cur_q, cur_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]        mask_q, mask_d;
    logic                 clr_flag_q, clr_flag_d;

    logic [NREQ-1:0]      gnt;
    logic [IDW-1:0]       win;
    logic                 cell_out;
    logic [ST_W-1:0]      cell_state;

    rr_arbiter #(.NREQ(NREQ), .PW(IDW)) u_arb (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt)
    );

    seq_detector u_cell (
        .in_i    (sh_q[DW-1]),
        .state_i (cur_q),
        .out_o   (cell_out),
        .state_o (cell_state)
    );

    // Encode the one-hot grant into the winning requester index.
    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) win = IDW'(i);
        end
    end

    // Next-state, datapath and output decode for the scheduler FSM.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        sh_d        = sh_q;
        cur_d       = cur_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        clr_flag_d  = clr_flag_q;
        ctx_d       = ctx_q;
        req_ready_o = '0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b0;

        // Clears for any context not currently being shifted take effect directly.
        for (int i = 0; i < NREQ; i++) begin
            if (ctx_clear_i[i] && !(state_q == SHIFT && id_q == IDW'(i))) begin
                ctx_d[i] = CTX_RESET;
            end
        end

        case (state_q)
            IDLE: begin
                req_ready_o = rst ? '0 : gnt;
                if (|gnt) begin
                    sh_d    = req_data_i[win*DW +: DW];
                    cur_d   = ctx_q[win];
                    id_d    = win;
                    cnt_d   = BIT_CNT_W'(DW - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy_o         = 1'b1;
                mask_d[cnt_q]  = cell_out;
                cur_d          = cell_state;
                sh_d           = sh_q << 1;
                cnt_d          = cnt_q - 1'b1;
                if (ctx_clear_i[id_q]) clr_flag_d = 1'b1;
                if (cnt_q == '0) begin
                    // A clear seen during this byte wins over the computed context.
                    ctx_d[id_q] = (clr_flag_q || ctx_clear_i[id_q]) ? CTX_RESET : cell_state;
                    state_d     = RESP;
                end
            end
            RESP: begin
                busy_o      = 1'b1;
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    rr_ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    clr_flag_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            sh_q       <= '0;
            cur_q      <= CTX_RESET;
            id_q       <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            clr_flag_q <= 1'b0;
            // NOTE: the context array is a handful of flops, so it is reset like any register.
            for (int i = 0; i < NREQ; i++) ctx_q[i] <= CTX_RESET;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            sh_q       <= sh_d;
            cur_q      <= cur_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            clr_flag_q <= clr_flag_d;
            ctx_q      <= ctx_d;
        end
    end

    // After the last shift cur_q holds the true final cell state.
    assign rsp_id_o    = id_q;
    assign rsp_mask_o  = mask_q;
    assign rsp_state_o = cur_q;

endmodule
